bch_encoder: RTL and testbench



---
 rtl/bch_pkg.sv | 20 ++
 rtl/bch_encoder_if.sv | 29 ++
 rtl/bch_parity_lfsr.sv | 20 ++
 rtl/bch_encoder.sv | 92 +++++++++
 tb/tb_bch_encoder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// Shared constants and types for the BCH(15,7) t=2 encode/decode path over GF(16).
package bch_pkg;

    localparam int BCH_N        = 15;
    localparam int BCH_K        = 7;
    localparam int BCH_PARITY_W = 8;

    // Generator g(x) = x^8 + x^7 + x^6 + x^4 + 1, bit i = coefficient of x^i.
    localparam logic [8:0] BCH_GEN_POLY = 9'h1D1;

    // GF(16) field polynomial x^4 + x + 1, used by the decoder stages.
    localparam logic [4:0] GF16_PRIM_POLY = 5'h13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } enc_state_t;

endpackage

// File: rtl/bch_encoder_if.sv
// Request/response bundle between a codeword consumer and the BCH encoder.
// The start/finished pair is a level-held handshake: start stays high until
// finished is seen, then drops for at least one clock.
interface bch_encoder_if;
    import bch_pkg::*;

    logic                    start_encode;
    logic [BCH_K-1:0]        message;
    logic [BCH_N-1:0]        codeword_out;
    logic                    finished_encode;
    logic                    busy;

    modport master (
        output start_encode,
        output message,
        input  codeword_out,
        input  finished_encode,
        input  busy
    );

    modport slave (
        input  start_encode,
        input  message,
        output codeword_out,
        output finished_encode,
        output busy
    );

endinterface

// File: rtl/bch_parity_lfsr.sv
// One step of the systematic-encoder division LFSR: folds a single message
// bit (MSB-first) into the running remainder of m(x)*x^8 mod g(x).
module bch_parity_lfsr
    import bch_pkg::*;
(
    input  logic [BCH_PARITY_W-1:0] rem_i,
    input  logic                    bit_i,
    output logic [BCH_PARITY_W-1:0] rem_o
);

    logic fb;

    // Feedback is the incoming bit plus the coefficient falling off x^7.
    always_comb begin
        fb    = bit_i ^ rem_i[BCH_PARITY_W-1];
        rem_o = {rem_i[BCH_PARITY_W-2:0], 1'b0}
              ^ (fb ? BCH_GEN_POLY[BCH_PARITY_W-1:0] : {BCH_PARITY_W{1'b0}});
    end

endmodule

// File: rtl/bch_encoder.sv
// Bit-serial systematic BCH(15,7) encoder. Latches the message on the start
// edge, shifts it MSB-first through the parity LFSR for K clocks and presents
// {message, parity} until the requester drops start.
module bch_encoder
    import bch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    bch_encoder_if.slave  enc
);

    localparam logic [2:0] LAST_CNT = 3'(BCH_K - 1);

    enc_state_t              state_q;
    logic [BCH_K-1:0]        msg_q;
    logic [BCH_PARITY_W-1:0] rem_q;
    logic [BCH_PARITY_W-1:0] rem_d;
    logic [2:0]              cnt_q;
    logic [BCH_N-1:0]        codeword_q;
    logic                    finished_q;
    logic                    busy_q;
    logic                    msg_bit;

    // Current message bit: coefficient of x^(K-1-cnt), highest power first.
    always_comb begin
        msg_bit = msg_q[LAST_CNT - cnt_q];
    end

    bch_parity_lfsr u_lfsr (
        .rem_i (rem_q),
        .bit_i (msg_bit),
        .rem_o (rem_d)
    );

    // Sequencing FSM; all outputs are registered so the handshake is glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            codeword_q <= '0;
            finished_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc.start_encode) begin
                        msg_q   <= enc.message;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!enc.start_encode) begin
                        // Abandoned request: partial remainder is never published.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 3'd1;
                        if (cnt_q == LAST_CNT) begin
                            codeword_q <= {msg_q, rem_d};
                            finished_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    // codeword_q is left alone so the last result stays readable.
                    if (!enc.start_encode) begin
                        finished_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    finished_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign enc.codeword_out    = codeword_q;
    assign enc.finished_encode = finished_q;
    assign enc.busy            = busy_q;

endmodule

// File: tb/tb_bch_encoder.sv
// Self-checking bench for bch_encoder: directed vector table, abort and
// asynchronous-reset sequences, and an all-message sweep against a
// long-division reference model.
module tb_bch_encoder;

    logic clk;
    logic rst;

    bch_encoder_if enc_if ();

    bch_encoder dut (
        .clk (clk),
        .rst (rst),
        .enc (enc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [6:0]  msg;
        logic [14:0] exp_cw;
    } vec_t;

    vec_t vecs [8];
    logic [14:0] cw_tab [128];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: remainder of a 15-bit polynomial divided by g(x) by long division.
    function automatic logic [7:0] poly_mod(input logic [14:0] v);
        logic [14:0] r;
        logic [14:0] g;
        r = v;
        g = 15'h01D1;
        for (int i = 14; i >= 8; i--) begin
            if (r[i]) r = r ^ (g << (i - 8));
        end
        return r[7:0];
    endfunction

    function automatic logic [14:0] model_cw(input logic [6:0] m);
        return {m, poly_mod({m, 8'h00})};
    endfunction

    // Full handshake: request, measure latency, check hold, release.
    task automatic run_encode(input logic [6:0] m, input bit full, output logic [14:0] cw);
        int lat;
        @(negedge clk);
        enc_if.message      = m;
        enc_if.start_encode = 1'b1;
        @(posedge clk);
        #1;
        if (full) check("busy_in_shift", 32'(enc_if.busy), 32'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!enc_if.finished_encode && lat < 20);
        check("latency", 32'(lat), 32'd7);
        cw = enc_if.codeword_out;
        if (full) begin
            check("busy_in_done", 32'(enc_if.busy), 32'd1);
            @(negedge clk);
            enc_if.message = ~m;
            @(posedge clk);
            #1;
            check("finished_hold", 32'(enc_if.finished_encode), 32'd1);
            check("codeword_hold", 32'(enc_if.codeword_out), 32'(model_cw(m)));
        end
        @(negedge clk);
        enc_if.start_encode = 1'b0;
        @(posedge clk);
        #1;
        if (full) begin
            check("finished_release", 32'(enc_if.finished_encode), 32'd0);
            check("busy_release", 32'(enc_if.busy), 32'd0);
            check("codeword_kept", 32'(enc_if.codeword_out), 32'(cw));
        end
    endtask

    initial begin
        logic [14:0] cw;
        logic [14:0] prev_cw;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{7'h01, 15'h01D1};
        vecs[1] = '{7'h40, 15'h40E8};
        vecs[2] = '{7'h7F, 15'h7FFF};
        vecs[3] = '{7'h00, 15'h0000};
        vecs[4] = '{7'h02, 15'h0273};
        vecs[5] = '{7'h03, 15'h03A2};
        vecs[6] = '{7'h08, 15'h081D};
        vecs[7] = '{7'h20, 15'h2074};

        enc_if.start_encode = 1'b0;
        enc_if.message      = 7'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_codeword", 32'(enc_if.codeword_out), 32'd0);
        check("rst_finished", 32'(enc_if.finished_encode), 32'd0);
        check("rst_busy", 32'(enc_if.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_encode(vecs[i].msg, 1'b1, cw);
            check($sformatf("vec%0d_codeword", i), 32'(cw), 32'(vecs[i].exp_cw));
        end

        // Abort after three SHIFT edges: nothing published, previous value kept.
        prev_cw = enc_if.codeword_out;
        @(negedge clk);
        enc_if.message      = 7'h55;
        enc_if.start_encode = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        enc_if.start_encode = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (enc_if.finished_encode) break;
        end
        check("abort_finished", 32'(enc_if.finished_encode), 32'd0);
        check("abort_busy", 32'(enc_if.busy), 32'd0);
        check("abort_codeword", 32'(enc_if.codeword_out), 32'(prev_cw));
        run_encode(7'h01, 1'b1, cw);
        check("after_abort_codeword", 32'(cw), 32'h01D1);

        // Asynchronous reset mid-SHIFT, applied away from a clock edge.
        @(negedge clk);
        enc_if.message      = 7'h55;
        enc_if.start_encode = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_codeword", 32'(enc_if.codeword_out), 32'd0);
        check("async_rst_finished", 32'(enc_if.finished_encode), 32'd0);
        check("async_rst_busy", 32'(enc_if.busy), 32'd0);
        enc_if.start_encode = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_encode(7'h01, 1'b1, cw);
        check("after_rst_codeword", 32'(cw), 32'h01D1);

        // All-message sweep: model agreement, divisibility, linearity.
        for (int a = 0; a < 128; a++) begin
            run_encode(7'(a), 1'b0, cw);
            cw_tab[a] = cw;
            check($sformatf("sweep_model_%0d", a), 32'(cw), 32'(model_cw(7'(a))));
            check($sformatf("sweep_divisible_%0d", a), 32'(poly_mod(cw)), 32'd0);
        end
        for (int a = 0; a < 128; a++) begin
            int b;
            b = (a * 5 + 3) & 127;
            check($sformatf("linearity_%0d_%0d", a, b),
                  32'(cw_tab[a] ^ cw_tab[b]), 32'(cw_tab[a ^ b]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
